alu: RTL and testbench

Parameterised signed integer ALU for the milestone-1 datapath. Combines two `BW`-bit two's-complement operands under a 4-bit opcode and registers the result together with overflow, negative and zero status flags. It sits between the register-file read ports and the write-back / branch logic, which consume `out` and `flags` one cycle after the operands are presented.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_addsub.sv | 22 ++
 rtl/alu.sv | 90 +++++++++
 tb/tb_alu.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and status-flag bit positions for the signed ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'b0000,
    OpSub  = 4'b0001,
    OpAnd  = 4'b0010,
    OpOr   = 4'b0011,
    OpXor  = 4'b0100,
    OpNot  = 4'b0101,
    OpInc  = 4'b0110,
    OpDec  = 4'b0111,
    OpMova = 4'b1000,
    OpMovb = 4'b1001,
    OpShl  = 4'b1010,
    OpShr  = 4'b1011,
    OpAsr  = 4'b1100,
    OpNeg  = 4'b1101
  } alu_op_e;

  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

endpackage

// File: rtl/alu_addsub.sv
// BW-bit adder with optional B inversion and carry-in; reports two's-complement overflow.
module alu_addsub #(
  parameter int unsigned BW = 16
) (
  input  logic [BW-1:0] a_i,
  input  logic [BW-1:0] b_i,
  input  logic          inv_b_i,
  input  logic          cin_i,
  output logic [BW-1:0] sum_o,
  output logic          ovf_o
);

  logic [BW-1:0] b_eff;

  always_comb begin
    b_eff = inv_b_i ? ~b_i : b_i;
    sum_o = a_i + b_eff + {{(BW-1){1'b0}}, cin_i};
    // Overflow when both effective addends agree in sign but the sum does not.
    ovf_o = (a_i[BW-1] == b_eff[BW-1]) && (sum_o[BW-1] != a_i[BW-1]);
  end

endmodule

// File: rtl/alu.sv
// Signed ALU: combinational opcode mux feeding a registered result and {V,N,Z} flags.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned BW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic [3:0]    opcode,
  output logic [BW-1:0] out,
  output logic [2:0]    flags
);

  logic [BW-1:0] add_a, add_b, add_sum;
  logic          add_inv, add_cin, add_ovf;
  logic [BW-1:0] out_d, out_q;
  logic [2:0]    flags_d, flags_q;
  logic          use_ovf;

  alu_addsub #(
    .BW(BW)
  ) u_addsub (
    .a_i     (add_a),
    .b_i     (add_b),
    .inv_b_i (add_inv),
    .cin_i   (add_cin),
    .sum_o   (add_sum),
    .ovf_o   (add_ovf)
  );

  always_comb begin
    add_a   = in_a;
    add_b   = in_b;
    add_inv = 1'b0;
    add_cin = 1'b0;
    use_ovf = 1'b0;
    out_d   = '0;
    case (opcode)
      OpAdd:  begin out_d = add_sum; use_ovf = 1'b1; end
      OpSub:  begin add_inv = 1'b1; add_cin = 1'b1; out_d = add_sum; use_ovf = 1'b1; end
      OpAnd:  out_d = in_a & in_b;
      OpOr:   out_d = in_a | in_b;
      OpXor:  out_d = in_a ^ in_b;
      OpNot:  out_d = ~in_a;
      OpInc:  begin add_b = '0; add_cin = 1'b1; out_d = add_sum; use_ovf = 1'b1; end
      OpDec:  begin
        // a - 1 as a + ~1 + 1
        add_b   = {{(BW-1){1'b0}}, 1'b1};
        add_inv = 1'b1;
        add_cin = 1'b1;
        out_d   = add_sum;
        use_ovf = 1'b1;
      end
      OpMova: out_d = in_a;
      OpMovb: out_d = in_b;
      OpShl:  out_d = {in_a[BW-2:0], 1'b0};
      OpShr:  out_d = {1'b0, in_a[BW-1:1]};
      OpAsr:  out_d = {in_a[BW-1], in_a[BW-1:1]};
      OpNeg:  begin
        add_a   = '0;
        add_b   = in_a;
        add_inv = 1'b1;
        add_cin = 1'b1;
        out_d   = add_sum;
        use_ovf = 1'b1;
      end
      default: out_d = '0;
    endcase
    flags_d         = 3'b000;
    flags_d[FLAG_V] = use_ovf & add_ovf;
    flags_d[FLAG_N] = out_d[BW-1];
    flags_d[FLAG_Z] = (out_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      flags_q <= 3'b001;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign out   = out_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the 16-bit ALU: reset, arithmetic, logic, shifts, pipelining.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] in_a, in_b;
  logic [3:0]  opcode;
  logic [15:0] out;
  logic [2:0]  flags;

  int checks;
  int errors;

  alu #(
    .BW(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .in_a   (in_a),
    .in_b   (in_b),
    .opcode (opcode),
    .out    (out),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation between edges, then step past the capturing edge.
  task automatic apply(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    opcode = o;
    in_a   = a;
    in_b   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if (out !== 16'h0000 || flags !== 3'b001) begin
      errors++;
      $display("FAIL reset_initial: out=%h flags=%b, want out=0000 flags=001", out, flags);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(OpMova, 16'h1234, 16'h0000);
    checks++;
    if (out !== 16'h1234 || flags !== 3'b000) begin
      errors++;
      $display("FAIL reset_preload: out=%h flags=%b, want out=1234 flags=000", out, flags);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 16'h0000 || flags !== 3'b001) begin
      errors++;
      $display("FAIL reset_async: out=%h flags=%b, want out=0000 flags=001", out, flags);
    end
    apply(OpMova, 16'h5555, 16'h0000);
    checks++;
    if (out !== 16'h0000 || flags !== 3'b001) begin
      errors++;
      $display("FAIL reset_hold: out=%h flags=%b, want out=0000 flags=001", out, flags);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(OpMova, 16'h0042, 16'h0000);
    checks++;
    if (out !== 16'h0042 || flags !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: out=%h flags=%b, want out=0042 flags=000", out, flags);
    end
  endtask

  task automatic test_arith;
    logic [3:0]  op  [6] = '{OpAdd, OpAdd, OpSub, OpSub, OpSub, OpNeg};
    logic [15:0] a   [6] = '{16'h7FFF, 16'h0003, 16'h0005, 16'h8000, 16'h0002, 16'h8000};
    logic [15:0] b   [6] = '{16'h0001, 16'h0004, 16'h0005, 16'h0001, 16'h0007, 16'h1111};
    logic [15:0] eo  [6] = '{16'h8000, 16'h0007, 16'h0000, 16'h7FFF, 16'hFFFB, 16'h8000};
    logic [2:0]  ef  [6] = '{3'b110, 3'b000, 3'b001, 3'b100, 3'b010, 3'b110};
    for (int i = 0; i < 6; i++) begin
      apply(op[i], a[i], b[i]);
      checks++;
      if (out !== eo[i] || flags !== ef[i]) begin
        errors++;
        $display("FAIL arith_%0d: out=%h flags=%b, want out=%h flags=%b",
                 i, out, flags, eo[i], ef[i]);
      end
    end
  endtask

  task automatic test_logic_shift;
    logic [3:0]  op  [7] = '{OpAnd, OpXor, OpNot, OpAsr, OpShr, OpShl, OpOr};
    logic [15:0] a   [7] = '{16'hF0F0, 16'hAAAA, 16'h0000, 16'h8004, 16'h8004, 16'h4000, 16'h1200};
    logic [15:0] b   [7] = '{16'h0FF0, 16'hAAAA, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0034};
    logic [15:0] eo  [7] = '{16'h00F0, 16'h0000, 16'hFFFF, 16'hC002, 16'h4002, 16'h8000, 16'h1234};
    logic [2:0]  ef  [7] = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b000, 3'b010, 3'b000};
    for (int i = 0; i < 7; i++) begin
      apply(op[i], a[i], b[i]);
      checks++;
      if (out !== eo[i] || flags !== ef[i]) begin
        errors++;
        $display("FAIL logic_shift_%0d: out=%h flags=%b, want out=%h flags=%b",
                 i, out, flags, eo[i], ef[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  op  [5] = '{OpInc, OpDec, OpMovb, 4'b1111, 4'b1110};
    logic [15:0] a   [5] = '{16'h7FFF, 16'h8000, 16'h7777, 16'hFFFF, 16'h8000};
    logic [15:0] b   [5] = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h8000};
    logic [15:0] eo  [5] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
    logic [2:0]  ef  [5] = '{3'b110, 3'b100, 3'b001, 3'b001, 3'b001};
    for (int i = 0; i < 5; i++) begin
      apply(op[i], a[i], b[i]);
      checks++;
      if (out !== eo[i] || flags !== ef[i]) begin
        errors++;
        $display("FAIL b2b_%0d: out=%h flags=%b, want out=%h flags=%b",
                 i, out, flags, eo[i], ef[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    in_a   = '0;
    in_b   = '0;
    opcode = '0;
    #12;
    test_reset();
    test_arith();
    test_logic_shift();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
